// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares one pipelined Wishbone master port between two requesters:
//   s1 = instruction fetch, s2 = load/store.
// Ownership is held for a whole Wishbone cycle (cyc). Load/store wins
// contention, except that once s2 has won STARVATION_LIMIT contended
// arbitrations in a row, s1 is forced to win. The number of strobes in
// flight without ack is bounded by MAX_OUTSTANDING.
//
// Handshake: a strobe is transferred on a clock edge where stb=1 and
// stall=0 (stb is "valid", ~stall is "ready"); an ack retires one
// transferred strobe. The requester must hold adr/dat/we/sel stable while
// stb=1 and stall=1.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   s1_wb_*             fetch-side Wishbone slave port
//   s2_wb_*             load/store-side Wishbone slave port
//   m_wb_*              external Wishbone master port
//   owner_o             0 idle, 1 s1 owns, 2 s2 owns (the FSM state itself)
module bus_arbiter #(
  parameter int MAX_OUTSTANDING  = 4,
  parameter int STARVATION_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] s1_wb_adr_i,
  output logic [31:0] s1_wb_dat_o,
  input  logic [31:0] s1_wb_dat_i,
  input  logic        s1_wb_we_i,
  input  logic [3:0]  s1_wb_sel_i,
  input  logic        s1_wb_stb_i,
  output logic        s1_wb_ack_o,
  input  logic        s1_wb_cyc_i,
  output logic        s1_wb_stall_o,
  input  logic [31:0] s2_wb_adr_i,
  output logic [31:0] s2_wb_dat_o,
  input  logic [31:0] s2_wb_dat_i,
  input  logic        s2_wb_we_i,
  input  logic [3:0]  s2_wb_sel_i,
  input  logic        s2_wb_stb_i,
  output logic        s2_wb_ack_o,
  input  logic        s2_wb_cyc_i,
  output logic        s2_wb_stall_o,
  output logic [31:0] m_wb_adr_o,
  input  logic [31:0] m_wb_dat_i,
  output logic [31:0] m_wb_dat_o,
  output logic        m_wb_we_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_stb_o,
  input  logic        m_wb_ack_i,
  output logic        m_wb_cyc_o,
  input  logic        m_wb_stall_i,
  output logic [1:0]  owner_o
);

  // Encoding doubles as owner_o, so the state is always observable.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_S1 = 2'd1,
    OWN_S2 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  starve_q, starve_d;

  logic        full;
  logic        own_cyc;
  logic        stb_fwd;
  logic        ack_fwd;

  // Read data fans out to both requesters; only ack qualifies it.
  assign s1_wb_dat_o = m_wb_dat_i;
  assign s2_wb_dat_o = m_wb_dat_i;
  assign owner_o     = state_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      starve_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (s1_wb_cyc_i && s2_wb_cyc_i) begin
          if (starve_q < 8'(STARVATION_LIMIT)) begin
            state_d = OWN_S2;
            if (starve_q != 8'hFF) starve_d = starve_q + 8'd1;
          end else begin
            state_d  = OWN_S1;
            starve_d = 8'd0;
          end
        end else if (s1_wb_cyc_i) begin
          state_d  = OWN_S1;
          starve_d = 8'd0;
        end else if (s2_wb_cyc_i) begin
          state_d = OWN_S2;
        end
      end
      OWN_S1, OWN_S2: begin
        // Dropping cyc ends ownership; acks still in flight are lost
        // because IDLE forwards none.
        if (!own_cyc) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (stb_fwd && !ack_fwd) begin
          cnt_d = cnt_q + 4'd1;
        end else if (!stb_fwd && ack_fwd) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    m_wb_adr_o    = 32'd0;
    m_wb_dat_o    = 32'd0;
    m_wb_we_o     = 1'b0;
    m_wb_sel_o    = 4'd0;
    m_wb_stb_o    = 1'b0;
    m_wb_cyc_o    = 1'b0;
    s1_wb_stall_o = 1'b1;
    s1_wb_ack_o   = 1'b0;
    s2_wb_stall_o = 1'b1;
    s2_wb_ack_o   = 1'b0;
    own_cyc       = 1'b0;
    full          = (cnt_q == 4'(MAX_OUTSTANDING));
    // An ack with nothing outstanding is spurious and is dropped.
    ack_fwd       = 1'b0;
    case (state_q)
      OWN_S1: begin
        own_cyc       = s1_wb_cyc_i;
        m_wb_adr_o    = s1_wb_adr_i;
        m_wb_dat_o    = s1_wb_dat_i;
        m_wb_we_o     = s1_wb_we_i;
        m_wb_sel_o    = s1_wb_sel_i;
        m_wb_cyc_o    = s1_wb_cyc_i;
        m_wb_stb_o    = s1_wb_stb_i & ~full;
        s1_wb_stall_o = m_wb_stall_i | full;
        ack_fwd       = m_wb_ack_i & (cnt_q != 4'd0);
        s1_wb_ack_o   = ack_fwd;
      end
      OWN_S2: begin
        own_cyc       = s2_wb_cyc_i;
        m_wb_adr_o    = s2_wb_adr_i;
        m_wb_dat_o    = s2_wb_dat_i;
        m_wb_we_o     = s2_wb_we_i;
        m_wb_sel_o    = s2_wb_sel_i;
        m_wb_cyc_o    = s2_wb_cyc_i;
        m_wb_stb_o    = s2_wb_stb_i & ~full;
        s2_wb_stall_o = m_wb_stall_i | full;
        ack_fwd       = m_wb_ack_i & (cnt_q != 4'd0);
        s2_wb_ack_o   = ack_fwd;
      end
      default: ;
    endcase
    stb_fwd = m_wb_stb_o & ~m_wb_stall_i;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (MAX_OUTSTANDING=4, STARVATION_LIMIT=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled one
// further unit later, well away from the next rising edge.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s1_adr, s1_dat_w, s1_dat_r;
  logic        s1_we, s1_stb, s1_ack, s1_cyc, s1_stall;
  logic [3:0]  s1_sel;
  logic [31:0] s2_adr, s2_dat_w, s2_dat_r;
  logic        s2_we, s2_stb, s2_ack, s2_cyc, s2_stall;
  logic [3:0]  s2_sel;
  logic [31:0] m_adr, m_dat_r, m_dat_w;
  logic        m_we, m_stb, m_ack, m_cyc, m_stall;
  logic [3:0]  m_sel;
  logic [1:0]  owner;

  int vectors     = 0;
  int miscompares = 0;

  // Clock
  always #5 clk = ~clk;

  bus_arbiter #(.MAX_OUTSTANDING(4), .STARVATION_LIMIT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .s1_wb_adr_i(s1_adr), .s1_wb_dat_o(s1_dat_r), .s1_wb_dat_i(s1_dat_w),
    .s1_wb_we_i(s1_we), .s1_wb_sel_i(s1_sel), .s1_wb_stb_i(s1_stb),
    .s1_wb_ack_o(s1_ack), .s1_wb_cyc_i(s1_cyc), .s1_wb_stall_o(s1_stall),
    .s2_wb_adr_i(s2_adr), .s2_wb_dat_o(s2_dat_r), .s2_wb_dat_i(s2_dat_w),
    .s2_wb_we_i(s2_we), .s2_wb_sel_i(s2_sel), .s2_wb_stb_i(s2_stb),
    .s2_wb_ack_o(s2_ack), .s2_wb_cyc_i(s2_cyc), .s2_wb_stall_o(s2_stall),
    .m_wb_adr_o(m_adr), .m_wb_dat_i(m_dat_r), .m_wb_dat_o(m_dat_w),
    .m_wb_we_o(m_we), .m_wb_sel_o(m_sel), .m_wb_stb_o(m_stb),
    .m_wb_ack_i(m_ack), .m_wb_cyc_o(m_cyc), .m_wb_stall_i(m_stall),
    .owner_o(owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    s1_adr = 32'd0; s1_dat_w = 32'd0; s1_we = 1'b0; s1_sel = 4'd0;
    s1_stb = 1'b0;  s1_cyc = 1'b0;
    s2_adr = 32'd0; s2_dat_w = 32'd0; s2_we = 1'b0; s2_sel = 4'd0;
    s2_stb = 1'b0;  s2_cyc = 1'b0;
    m_dat_r = 32'd0; m_ack = 1'b0; m_stall = 1'b0;

    // ---- Reset: two cycles, then release with all cyc low
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_m_cyc", 32'(m_cyc), 32'd0);
    chk("rst_m_stb", 32'(m_stb), 32'd0);
    chk("rst_s1_stall", 32'(s1_stall), 32'd1);
    chk("rst_s2_stall", 32'(s2_stall), 32'd1);
    chk("rst_owner", 32'(owner), 32'd0);

    // ---- Single fetch
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_adr = 32'h0000_1000; s1_sel = 4'hF;
    settle();
    chk("idle_adr_zero", m_adr, 32'd0);
    chk("idle_owner", 32'(owner), 32'd0);
    tick();
    chk("f_owner", 32'(owner), 32'd1);
    chk("f_m_cyc", 32'(m_cyc), 32'd1);
    chk("f_m_stb", 32'(m_stb), 32'd1);
    chk("f_m_adr", m_adr, 32'h0000_1000);
    chk("f_s1_stall", 32'(s1_stall), 32'd0);
    chk("f_s2_stall", 32'(s2_stall), 32'd1);
    tick();                       // strobe accepted, one outstanding
    s1_stb = 1'b0; m_ack = 1'b1; m_dat_r = 32'hDEAD_BEEF;
    settle();
    chk("f_s1_ack", 32'(s1_ack), 32'd1);
    chk("f_s1_dat", s1_dat_r, 32'hDEAD_BEEF);
    chk("f_s2_dat", s2_dat_r, 32'hDEAD_BEEF);
    chk("f_s2_ack", 32'(s2_ack), 32'd0);
    tick();
    m_ack = 1'b0; s1_cyc = 1'b0;
    settle();
    chk("f_cyc_drop_m_cyc", 32'(m_cyc), 32'd0);
    tick();
    chk("f_release_owner", 32'(owner), 32'd0);

    // ---- Contention: both raise cyc together, s2 wins
    s1_cyc = 1'b1; s1_stb = 1'b1;
    s2_cyc = 1'b1; s2_stb = 1'b1; s2_adr = 32'h0000_2000;
    s2_we = 1'b1; s2_dat_w = 32'hCAFE_F00D; s2_sel = 4'h3;
    tick();
    chk("c_owner", 32'(owner), 32'd2);
    chk("c_m_adr", m_adr, 32'h0000_2000);
    chk("c_m_dat", m_dat_w, 32'hCAFE_F00D);
    chk("c_m_we", 32'(m_we), 32'd1);
    chk("c_m_sel", 32'(m_sel), 32'h3);
    chk("c_s1_stall", 32'(s1_stall), 32'd1);
    tick();                       // s2 strobe accepted
    s2_stb = 1'b0; m_ack = 1'b1;
    settle();
    chk("c_s1_ack_blocked", 32'(s1_ack), 32'd0);
    chk("c_s2_ack", 32'(s2_ack), 32'd1);
    tick();                       // outstanding back to 0
    settle();
    chk("c_spurious_ack", 32'(s2_ack), 32'd0);
    m_ack = 1'b0; s2_cyc = 1'b0; s2_we = 1'b0;
    tick();
    chk("c_release_owner", 32'(owner), 32'd0);

    // ---- Starvation: clear starve via reset, s1 holds cyc throughout
    s1_stb = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      s2_cyc = 1'b1; s2_stb = 1'b1;
      tick();
      chk($sformatf("s_grant%0d_owner", r + 1), 32'(owner), 32'd2);
      tick();                     // strobe accepted
      s2_stb = 1'b0; m_ack = 1'b1;
      settle();
      chk($sformatf("s_grant%0d_ack", r + 1), 32'(s2_ack), 32'd1);
      tick();
      m_ack = 1'b0; s2_cyc = 1'b0;
      tick();                     // back in IDLE
    end
    s2_cyc = 1'b1; s2_stb = 1'b1;
    tick();
    chk("s_ninth_owner", 32'(owner), 32'd1);
    chk("s_ninth_s2_stall", 32'(s2_stall), 32'd1);
    s2_cyc = 1'b0; s2_stb = 1'b0;

    // ---- Outstanding limit: s1 owns with nothing outstanding
    s1_stb = 1'b1; s1_adr = 32'h0000_3000;
    settle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("o_stb%0d", k + 1), 32'(m_stb), 32'd1);
      chk($sformatf("o_stall%0d", k + 1), 32'(s1_stall), 32'd0);
      tick();
    end
    chk("o_full_stb", 32'(m_stb), 32'd0);
    chk("o_full_stall", 32'(s1_stall), 32'd1);
    m_ack = 1'b1;
    settle();
    chk("o_ack", 32'(s1_ack), 32'd1);
    chk("o_ack_still_full", 32'(m_stb), 32'd0);
    tick();
    m_ack = 1'b0;
    settle();
    chk("o_fifth_stb", 32'(m_stb), 32'd1);
    chk("o_fifth_stall", 32'(s1_stall), 32'd0);
    tick();
    chk("o_full_again", 32'(s1_stall), 32'd1);
    s1_stb = 1'b0; s1_cyc = 1'b0;
    tick();
    chk("o_release_owner", 32'(owner), 32'd0);

    // ---- Reset mid-transaction: s2 owns with two outstanding
    s2_cyc = 1'b1; s2_stb = 1'b1;
    tick();
    chk("r_owner", 32'(owner), 32'd2);
    tick(); tick();               // two strobes accepted
    s2_stb = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; s2_cyc = 1'b0;
    settle();
    chk("r_owner_after_rst", 32'(owner), 32'd0);
    m_ack = 1'b1;
    settle();
    chk("r_s1_ack", 32'(s1_ack), 32'd0);
    chk("r_s2_ack", 32'(s2_ack), 32'd0);
    tick();
    chk("r_s2_ack_2", 32'(s2_ack), 32'd0);
    // Regrant: the counter was cleared, so an ack is spurious
    s2_cyc = 1'b1;
    tick();
    chk("r_regrant_owner", 32'(owner), 32'd2);
    chk("r_regrant_ack", 32'(s2_ack), 32'd0);
    m_ack = 1'b0; s2_cyc = 1'b0;
    tick();
    chk("r_final_owner", 32'(owner), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
